resstream_luma4x4: RTL and testbench
====================================

// Module: resstream_luma4x4
// PURPOSE
//  Downstream stage of the 4x4 luma intra predictor. Accepts the chosen 4x4 residual block
//  (16 samples, mode, mbnumber) in one beat and emits it one sample per cycle to the
//  transform/entropy stage over a valid/ready stream. Two-slot ping-pong buffer lets the
//  predictor deliver the next block while the current one drains.
// PARAMETERS
//  MB_NUMBER_BITS  12  mbnumber width is MB_NUMBER_BITS+1 (matches predictor)
//  RES_WIDTH       8   bits per residual sample
//  ZIGZAG          1   1: emit in 4x4 zigzag scan order; 0: raster order
// PORTS
//  clk           in   1                   clock, all state on rising edge
//  reset         in   1                   asynchronous, active-high; clears all state
//  enable        in   1                   0: freeze all state, in_ready=0, out_valid=0
//  in_valid      in   1                   predictor offers a block
//  in_ready      out  1                   buffer can accept a block this cycle
//  in_res        in   16 x RES_WIDTH      residual samples, index = 4*row+col (raster)
//  in_mode       in   3                   selected prediction mode
//  in_mbnumber   in   MB_NUMBER_BITS+1    block number
//  out_valid     out  1                   out_* carry a valid sample
//  out_ready     in   1                   consumer takes sample when out_valid&out_ready
//  out_data      out  RES_WIDTH           current residual sample
//  out_pos       out  4                   raster index (4*row+col) of out_data
//  out_mode      out  3                   mode of block being drained
//  out_mbnumber  out  MB_NUMBER_BITS+1    mbnumber of block being drained
//  out_last      out  1                   1 on 16th sample of a block
// BEHAVIOUR
//  - State: slot[0..1] {16 samples, mode, mbnumber}; wr_ptr, rd_ptr (1b); count (0..2);
//    scan index idx (4b).
//  - Reset: count=0, wr_ptr=rd_ptr=0, idx=0, slot contents 0. Resulting outputs:
//    out_valid=0, out_last=0, out_data=0, out_pos=0, out_mode=0, out_mbnumber=0,
//    in_ready=enable.
//  - Reset asserted mid-block discards both slots; no partial block resumes.
//  - in_ready = enable & (count<2). It depends only on registered count, with no
//    combinational path from out_ready.
//  - Push (in_valid&in_ready):
//    - all inputs are captured into slot[wr_ptr];
//    - wr_ptr toggles.
//  - out_valid = enable & (count>0).
//  - Output mapping:
//    - out_pos = ZIGZAG ? zz[idx] : idx;
//    - out_data = slot[rd_ptr].res[out_pos];
//    - out_mode and out_mbnumber are taken from slot[rd_ptr].
//  - Zigzag table zz[0..15] = 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
//  - out_last = out_valid & (idx==15).
//  - Pop (out_valid&out_ready):
//    - if idx<15, idx increments;
//    - if idx==15, idx=0, rd_ptr toggles and the slot is released.
//  - count next value:
//    - push and release in the same cycle: count unchanged (only possible at count=1);
//    - push only: +1;
//    - release only: -1.
//  - At count==2 a push is impossible (in_ready=0), even if release occurs that cycle.
//  - Latency: a block pushed at edge N is visible (out_valid=1, idx=0) after edge N. The
//    first sample pops at edge N+1 at the earliest.
//  - Throughput: 16 cycles/block with out_ready held 1. Back-to-back blocks drain with no
//    bubble when the next slot is already full.
//  - out_ready=0: all out_* held stable while out_valid=1.
//  - enable=0 in any cycle: no push, no pop, no state change.
//  - Slot contents are untouched until released and overwritten by a later push.
// TESTING
//  1. Reset, enable=1: push res[i]=i, mode=2, mb=5, ZIGZAG=0, out_ready=1 -> out_data
//     0..15 on 16 consecutive cycles, out_last only on 15, out_mode=2, out_mbnumber=5.
//  2. ZIGZAG=1, res[i]=i -> out_data/out_pos sequence 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
//  3. Push A, B, C with out_ready=0 -> A and B accepted, in_ready=0 for C. Then set
//     out_ready=1 -> 32 samples A then B with no gap, C accepted the cycle after A's last pop.
//  4. count=1, push coinciding with last pop of A -> count stays 1; the next cycle shows
//     B sample idx 0.
//  5. Random out_ready toggling for 100 blocks -> every sample delivered exactly once, in
//     order, out_* stable while stalled.
//  6. Assert reset at idx=7 with 2 slots full -> next cycle out_valid=0, in_ready=1.
//     Deassert enable mid-block -> idx frozen and resumes at same sample when re-enabled.

Source files
------------

// File: rtl/resstream_luma4x4_if.sv
// Stream bundle between the 4x4 luma predictor, the residual buffer and the
// transform/entropy consumer: one block-wide input beat and a per-sample output.
interface resstream_luma4x4_if #(
   parameter int MB_NUMBER_BITS = 12,
   parameter int RES_WIDTH      = 8
);
   logic                            in_valid;
   logic                            in_ready;
   logic [15:0][RES_WIDTH-1:0]      in_res;
   logic [2:0]                      in_mode;
   logic [MB_NUMBER_BITS:0]         in_mbnumber;

   logic                            out_valid;
   logic                            out_ready;
   logic [RES_WIDTH-1:0]            out_data;
   logic [3:0]                      out_pos;
   logic [2:0]                      out_mode;
   logic [MB_NUMBER_BITS:0]         out_mbnumber;
   logic                            out_last;

   // Producer/consumer side: offers blocks and accepts samples.
   modport master (
      output in_valid, in_res, in_mode, in_mbnumber, out_ready,
      input  in_ready, out_valid, out_data, out_pos, out_mode, out_mbnumber, out_last
   );

   // Buffer side.
   modport slave (
      input  in_valid, in_res, in_mode, in_mbnumber, out_ready,
      output in_ready, out_valid, out_data, out_pos, out_mode, out_mbnumber, out_last
   );
endinterface

// File: rtl/resstream_luma4x4.sv
// Residual block serializer for the 4x4 luma intra predictor.
// Takes a whole 4x4 residual block in one beat into a two-slot ping-pong buffer
// and drains it one sample per cycle, in raster or zigzag scan order.
module resstream_luma4x4 #(
   parameter int MB_NUMBER_BITS = 12,
   parameter int RES_WIDTH      = 8,
   parameter int ZIGZAG         = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   resstream_luma4x4_if.slave   bus
);

   localparam int MBW = MB_NUMBER_BITS + 1;

   logic [1:0][15:0][RES_WIDTH-1:0] slot_res;
   logic [1:0][2:0]                 slot_mode;
   logic [1:0][MBW-1:0]             slot_mb;

   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic [3:0] idx;

   logic       push;
   logic       pop;
   logic       release_slot;
   logic [3:0] pos;

   // Raster position visited at each step of the 4x4 zigzag scan.
   function automatic logic [3:0] zz_pos(input logic [3:0] i);
      logic [3:0] p;
      case (i)
         4'd0:    p = 4'd0;
         4'd1:    p = 4'd1;
         4'd2:    p = 4'd4;
         4'd3:    p = 4'd8;
         4'd4:    p = 4'd5;
         4'd5:    p = 4'd2;
         4'd6:    p = 4'd3;
         4'd7:    p = 4'd6;
         4'd8:    p = 4'd9;
         4'd9:    p = 4'd12;
         4'd10:   p = 4'd13;
         4'd11:   p = 4'd10;
         4'd12:   p = 4'd7;
         4'd13:   p = 4'd11;
         4'd14:   p = 4'd14;
         default: p = 4'd15;
      endcase
      return p;
   endfunction

   // Handshakes only look at registered occupancy, so in_ready never depends on out_ready.
   assign bus.in_ready  = enable & (count < 2'd2);
   assign bus.out_valid = enable & (count != 2'd0);

   assign push         = bus.in_valid & bus.in_ready;
   assign pop          = bus.out_valid & bus.out_ready;
   assign release_slot = pop & (idx == 4'd15);

   assign pos = (ZIGZAG != 0) ? zz_pos(idx) : idx;

   assign bus.out_pos      = pos;
   assign bus.out_data     = slot_res[rd_ptr][pos];
   assign bus.out_mode     = slot_mode[rd_ptr];
   assign bus.out_mbnumber = slot_mb[rd_ptr];
   assign bus.out_last     = bus.out_valid & (idx == 4'd15);

   // Capture an accepted block into the write slot; other slot is left alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_res  <= '0;
         slot_mode <= '0;
         slot_mb   <= '0;
      end else if (push) begin
         slot_res[wr_ptr]  <= bus.in_res;
         slot_mode[wr_ptr] <= bus.in_mode;
         slot_mb[wr_ptr]   <= bus.in_mbnumber;
      end
   end

   // Pointer, occupancy and scan-index bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         idx    <= 4'd0;
      end else begin
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            if (idx == 4'd15) begin
               idx    <= 4'd0;
               rd_ptr <= ~rd_ptr;
            end else begin
               idx <= idx + 4'd1;
            end
         end
         if (push && !release_slot) begin
            count <= count + 2'd1;
         end else if (release_slot && !push) begin
            count <= count - 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_resstream_luma4x4.sv
// Bench for resstream_luma4x4: two instances (raster and zigzag) share the same
// stimulus and are compared against a block-queue reference model.
module tb_resstream_luma4x4;

   typedef struct {
      logic [15:0][7:0] res;
      logic [2:0]       mode;
      logic [12:0]      mb;
   } blk_t;

   logic clk;
   logic reset;
   logic enable;

   int total;
   int bad;

   blk_t q[$];
   int   k;
   int   zz_tab[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
   int   pops_seen;

   resstream_luma4x4_if #(.MB_NUMBER_BITS(12), .RES_WIDTH(8)) bus0 ();
   resstream_luma4x4_if #(.MB_NUMBER_BITS(12), .RES_WIDTH(8)) bus1 ();

   resstream_luma4x4 #(.MB_NUMBER_BITS(12), .RES_WIDTH(8), .ZIGZAG(0)) dut_raster (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .bus    (bus0)
   );

   resstream_luma4x4 #(.MB_NUMBER_BITS(12), .RES_WIDTH(8), .ZIGZAG(1)) dut_zigzag (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .bus    (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic blk_t rampBlk(input logic [2:0] mode, input logic [12:0] mb);
      blk_t b;
      for (int i = 0; i < 16; i++) b.res[i] = 8'(i);
      b.mode = mode;
      b.mb   = mb;
      return b;
   endfunction

   function automatic blk_t randBlk();
      blk_t b;
      for (int i = 0; i < 16; i++) b.res[i] = 8'($urandom);
      b.mode = 3'($urandom);
      b.mb   = 13'($urandom);
      return b;
   endfunction

   task automatic driveInputs(input bit en, input bit iv, input blk_t b, input bit ordy);
      enable           = en;
      bus0.in_valid    = iv;
      bus1.in_valid    = iv;
      bus0.in_res      = b.res;
      bus1.in_res      = b.res;
      bus0.in_mode     = b.mode;
      bus1.in_mode     = b.mode;
      bus0.in_mbnumber = b.mb;
      bus1.in_mbnumber = b.mb;
      bus0.out_ready   = ordy;
      bus1.out_ready   = ordy;
   endtask

   // One clock cycle: drive, check at the falling edge, advance the model at the rising edge.
   task automatic applyStimulus(input bit en, input bit iv, input blk_t b, input bit ordy,
                                output bit accepted);
      bit exp_ir;
      bit exp_ov;
      bit do_pop;
      int p0;
      int p1;
      driveInputs(en, iv, b, ordy);
      @(negedge clk);
      exp_ir = en && (q.size() < 2);
      exp_ov = en && (q.size() > 0);
      checkOutput("in_ready_r", 32'(bus0.in_ready), 32'(exp_ir));
      checkOutput("in_ready_z", 32'(bus1.in_ready), 32'(exp_ir));
      checkOutput("out_valid_r", 32'(bus0.out_valid), 32'(exp_ov));
      checkOutput("out_valid_z", 32'(bus1.out_valid), 32'(exp_ov));
      if (q.size() > 0) begin
         p0 = k;
         p1 = zz_tab[k];
         checkOutput("data_r", 32'(bus0.out_data), 32'(q[0].res[p0]));
         checkOutput("pos_r", 32'(bus0.out_pos), 32'(p0));
         checkOutput("data_z", 32'(bus1.out_data), 32'(q[0].res[p1]));
         checkOutput("pos_z", 32'(bus1.out_pos), 32'(p1));
         checkOutput("mode_r", 32'(bus0.out_mode), 32'(q[0].mode));
         checkOutput("mb_r", 32'(bus0.out_mbnumber), 32'(q[0].mb));
         checkOutput("mode_z", 32'(bus1.out_mode), 32'(q[0].mode));
         checkOutput("mb_z", 32'(bus1.out_mbnumber), 32'(q[0].mb));
         checkOutput("last_r", 32'(bus0.out_last), 32'(exp_ov && k == 15));
         checkOutput("last_z", 32'(bus1.out_last), 32'(exp_ov && k == 15));
      end else begin
         checkOutput("last_r_idle", 32'(bus0.out_last), 32'(0));
         checkOutput("last_z_idle", 32'(bus1.out_last), 32'(0));
      end
      if (bus0.out_valid === 1'b1 && ordy) pops_seen++;
      accepted = iv && exp_ir;
      do_pop   = exp_ov && ordy;
      @(posedge clk);
      if (do_pop) begin
         if (k == 15) begin
            k = 0;
            void'(q.pop_front());
         end else begin
            k++;
         end
      end
      if (accepted) q.push_back(b);
      #1;
   endtask

   task automatic doReset();
      blk_t z;
      z.res  = '0;
      z.mode = '0;
      z.mb   = '0;
      driveInputs(1'b1, 1'b0, z, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rst_out_valid", 32'(bus0.out_valid), 32'(0));
      checkOutput("rst_in_ready", 32'(bus0.in_ready), 32'(1));
      checkOutput("rst_last", 32'(bus0.out_last), 32'(0));
      checkOutput("rst_data_r", 32'(bus0.out_data), 32'(0));
      checkOutput("rst_pos_z", 32'(bus1.out_pos), 32'(0));
      checkOutput("rst_data_z", 32'(bus1.out_data), 32'(0));
      checkOutput("rst_mode", 32'(bus0.out_mode), 32'(0));
      checkOutput("rst_mb", 32'(bus1.out_mbnumber), 32'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      q.delete();
      k = 0;
   endtask

   initial begin
      blk_t nb;
      blk_t blk_a;
      blk_t blk_b;
      blk_t blk_c;
      bit   acc;
      int   waited;
      int   pushed;
      int   cycles;

      total     = 0;
      bad       = 0;
      k         = 0;
      pops_seen = 0;
      reset     = 1'b1;
      nb        = rampBlk(3'd0, 13'd0);
      driveInputs(1'b1, 1'b0, nb, 1'b0);
      #12;
      doReset();

      // Ramp block, drained with out_ready held high (raster and zigzag lanes).
      nb = rampBlk(3'd2, 13'd5);
      applyStimulus(1'b1, 1'b1, nb, 1'b1, acc);
      checkOutput("t1_accept", 32'(acc), 32'(1));
      for (int i = 0; i < 18; i++) applyStimulus(1'b1, 1'b0, nb, 1'b1, acc);

      // Fill both slots while stalled; third block must wait for the first to drain.
      blk_a = randBlk();
      blk_b = randBlk();
      blk_c = randBlk();
      applyStimulus(1'b1, 1'b1, blk_a, 1'b0, acc);
      applyStimulus(1'b1, 1'b1, blk_b, 1'b0, acc);
      applyStimulus(1'b1, 1'b1, blk_c, 1'b0, acc);
      checkOutput("t3_c_refused", 32'(acc), 32'(0));
      waited = 0;
      acc    = 1'b0;
      while (!acc && waited < 40) begin
         applyStimulus(1'b1, 1'b1, blk_c, 1'b1, acc);
         waited++;
      end
      checkOutput("t3_c_wait", 32'(waited), 32'(17));
      for (int i = 0; i < 34; i++) applyStimulus(1'b1, 1'b0, blk_c, 1'b1, acc);

      // Push landing on the last pop of the only block in flight.
      blk_a = randBlk();
      blk_b = randBlk();
      applyStimulus(1'b1, 1'b1, blk_a, 1'b1, acc);
      for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, blk_a, 1'b1, acc);
      applyStimulus(1'b1, 1'b1, blk_b, 1'b1, acc);
      checkOutput("t4_b_accept", 32'(acc), 32'(1));
      for (int i = 0; i < 18; i++) applyStimulus(1'b1, 1'b0, blk_b, 1'b1, acc);

      // Reset in the middle of a block with both slots occupied.
      blk_a = randBlk();
      blk_b = randBlk();
      applyStimulus(1'b1, 1'b1, blk_a, 1'b0, acc);
      applyStimulus(1'b1, 1'b1, blk_b, 1'b0, acc);
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, blk_b, 1'b1, acc);
      doReset();

      // Freeze with enable low mid-block, then resume at the same sample.
      blk_a = randBlk();
      applyStimulus(1'b1, 1'b1, blk_a, 1'b0, acc);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, blk_a, 1'b1, acc);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, blk_a, 1'b1, acc);
      for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0, blk_a, 1'b1, acc);

      // Randomized traffic: 100 blocks with random out_ready, in_valid and enable.
      doReset();
      pops_seen = 0;
      pushed    = 0;
      cycles    = 0;
      nb        = randBlk();
      while ((pushed < 100 || q.size() > 0) && cycles < 12000) begin
         applyStimulus(($urandom % 16) != 0, (pushed < 100) && (($urandom % 4) != 0),
                       nb, ($urandom % 3) != 0, acc);
         if (acc) begin
            pushed++;
            nb = randBlk();
         end
         cycles++;
      end
      checkOutput("rand_drained", 32'(cycles < 12000), 32'(1));
      checkOutput("rand_pop_count", 32'(pops_seen), 32'(1600));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
